and_or_checker: RTL

AND_OR_CHECKER -- requirements
Module: and_or_checker

---
 rtl/and_or_checker_if.sv | 15 +
 rtl/and_or_checker.sv | 74 +++++++
 2 files changed

// File: rtl/and_or_checker_if.sv
// and_or_checker_if: stimulus/DUT-observation bundle and verdict outputs of the AND/OR checker.
interface and_or_checker_if #(parameter int CNT_W = 8);
    logic             start;
    logic             a;
    logic             b;
    logic             y;
    logic             z;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [3:0]       cov;
    modport master (output start, a, b, y, z, input busy, done, pass, err_cnt, cov);
    modport slave  (input start, a, b, y, z, output busy, done, pass, err_cnt, cov);
endinterface

// File: rtl/and_or_checker.sv
// and_or_checker: checks a 2-input AND/OR DUT with LAT-cycle latency over NUM_VEC vectors,
// counting mismatches and recording which {a,b} combinations were exercised.
module and_or_checker #(
    parameter int LAT     = 0,
    parameter int NUM_VEC = 16,
    parameter int CNT_W   = 8
) (
    input logic             clk,
    input logic             rst,
    and_or_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;
    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [3:0]       cov_q, cov_d;
    logic             ad, bd, mis, run;
    // Delay line runs regardless of state so expected values are valid on the first CHECK cycle
    if (LAT == 0) begin : g_nodl
        assign ad = bus.a;
        assign bd = bus.b;
    end else begin : g_dl
        logic [LAT-1:0] da_q, db_q;
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                da_q <= '0;
                db_q <= '0;
            end else begin
                da_q <= (da_q << 1) | LAT'(bus.a);
                db_q <= (db_q << 1) | LAT'(bus.b);
            end
        assign ad = da_q[LAT-1];
        assign bd = db_q[LAT-1];
    end
    assign mis = (bus.y !== (ad & bd)) || (bus.z !== (ad | bd));
    assign run = bus.start && (state_q == IDLE || state_q == DONE);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cov_d   = cov_q;
        if (run) begin
            state_d = (LAT > 0) ? FILL : CHECK;
            cnt_d   = '0;
            err_d   = '0;
            cov_d   = '0;
        end else if (state_q == FILL) begin
            state_d = (cnt_q == 8'(LAT - 1)) ? CHECK : FILL;
            cnt_d   = (cnt_q == 8'(LAT - 1)) ? 8'd0 : cnt_q + 8'd1;
        end else if (state_q == CHECK) begin
            state_d = (cnt_q == 8'(NUM_VEC - 1)) ? DONE : CHECK;
            cnt_d   = cnt_q + 8'd1;
            err_d   = (mis && !(&err_q)) ? err_q + 1'b1 : err_q;
            cov_d   = cov_q | (4'b0001 << {ad, bd});
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            cov_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            cov_q   <= cov_d;
        end
    assign bus.busy    = (state_q == FILL) || (state_q == CHECK);
    assign bus.done    = (state_q == DONE);
    assign bus.pass    = (state_q == DONE) && (err_q == '0) && (cov_q == 4'hF);
    assign bus.err_cnt = err_q;
    assign bus.cov     = cov_q;
endmodule
